// File: rtl/apb_i2c_master_fifo.sv
// APB-slave I2C master with TX/RX byte FIFOs, programmable SCL quarter-period
// divider, multi-byte read/write bursts and sticky NACK/overflow flags.
module apb_i2c_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wp, rp;

  assign level = wp - rp;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (wp == rp);
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk)
    if (push && !full && !flush) mem[wp[AW-1:0]] <= din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

module apb_i2c_master_fifo #(
  parameter int FIFO_DEPTH  = 4,
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 250
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [31:0] PADDR,
  input  logic        PSELx,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  inout  wire         SDA,
  output logic        SCL
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [3:0] {IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, STOP} state_t;
  state_t state, state_nx;

  logic             en, rw, nack, ovf, have, ack_bit, sda_low, set_nack;
  logic [7:0]       cnt_reg, cnt, sh;
  logic [6:0]       saddr;
  logic [DIV_W-1:0] div, dmax, qcnt;
  logic [1:0]       q;
  logic [2:0]       bitcnt;
  logic [7:0]       tx_dout, rx_dout;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [AW:0]      tx_lvl, rx_lvl;
  logic             sda_in, unused_ok;

  wire apb_wr  = PSELx & PENABLE & PWRITE;
  wire apb_rd  = PSELx & PENABLE & ~PWRITE;
  wire ctrl_wr = apb_wr && (PADDR[3:2] == 2'd0);
  wire data_wr = apb_wr && (PADDR[3:2] == 2'd2);
  wire div_wr  = apb_wr && (PADDR[3:2] == 2'd3);
  wire rx_pop  = apb_rd && (PADDR[3:2] == 2'd2);
  // Disabling via a CTRL write takes effect on the same edge the write commits.
  wire en_nx   = ctrl_wr ? PWDATA[0] : en;
  wire go      = ctrl_wr && PWDATA[1] && PWDATA[0] && (state == IDLE);
  wire stall   = ((state == WDATA) || (state == RACK)) && !have;
  wire tick    = (state != IDLE) && !stall && (qcnt == dmax);
  wire sample  = tick && (q == 2'd2);
  wire bit_end = tick && (q == 2'd3);
  wire tx_pop  = (state == WDATA) && !have && !tx_empty;
  wire rx_push = (state == RACK) && !have && !rx_full;

  assign dmax      = (div == '0) ? DIV_W'(1) : div;
  assign sda_in    = SDA;
  assign SDA       = sda_low ? 1'b0 : 1'bz;
  assign unused_ok = ^{PADDR[31:4], PADDR[1:0], PWDATA};

  apb_i2c_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk(PCLK), .rst_n(PRESETn), .flush(!en_nx || set_nack), .push(data_wr), .pop(tx_pop),
    .din(PWDATA[7:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty), .level(tx_lvl));

  apb_i2c_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk(PCLK), .rst_n(PRESETn), .flush(!en_nx), .push(rx_push), .pop(rx_pop),
    .din(sh), .dout(rx_dout), .full(rx_full), .empty(rx_empty), .level(rx_lvl));

  always_comb begin
    state_nx = state;
    set_nack = 1'b0;
    SCL      = 1'b1;
    sda_low  = 1'b0;
    case (state)
      IDLE:     if (go) state_nx = START;
      START:    begin sda_low = 1'b1; if (tick) state_nx = ADDR; end
      ADDR:     begin
        SCL = q[1]; sda_low = ~sh[7];
        if (bit_end && bitcnt == 3'd0) state_nx = ADDR_ACK;
      end
      ADDR_ACK: begin
        SCL = q[1];
        if (bit_end) begin
          if (ack_bit)          begin state_nx = STOP; set_nack = 1'b1; end
          else if (cnt == 8'd0) state_nx = STOP;
          else                  state_nx = rw ? RDATA : WDATA;
        end
      end
      WDATA:    begin
        SCL = q[1]; sda_low = have & ~sh[7];
        if (bit_end && bitcnt == 3'd0) state_nx = WACK;
      end
      WACK:     begin
        SCL = q[1];
        if (bit_end) begin
          if (ack_bit) begin state_nx = STOP; set_nack = 1'b1; end
          else         state_nx = (cnt == 8'd1) ? STOP : WDATA;
        end
      end
      RDATA:    begin
        SCL = q[1];
        if (bit_end && bitcnt == 3'd0) state_nx = RACK;
      end
      // The byte is pushed at the start of RACK; a full RX FIFO stalls here with SCL low.
      RACK:     begin
        SCL = q[1]; sda_low = have & (cnt != 8'd1);
        if (bit_end) state_nx = (cnt == 8'd1) ? STOP : RDATA;
      end
      STOP:     begin
        SCL = q[1]; sda_low = (q != 2'd3);
        if (bit_end) state_nx = IDLE;
      end
      default:  state_nx = IDLE;
    endcase
    if (!en_nx) state_nx = IDLE;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      en      <= 1'b0;
      rw      <= 1'b0;
      cnt_reg <= '0;
      saddr   <= '0;
      div     <= DIV_W'(DIV_DEFAULT);
      qcnt    <= '0;
      q       <= '0;
      bitcnt  <= '0;
      sh      <= '0;
      have    <= 1'b0;
      cnt     <= '0;
      ack_bit <= 1'b0;
      nack    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state <= state_nx;
      if (ctrl_wr) begin
        en      <= PWDATA[0];
        rw      <= PWDATA[2];
        cnt_reg <= PWDATA[15:8];
        saddr   <= PWDATA[22:16];
      end
      if (div_wr) div <= PWDATA[DIV_W-1:0];
      qcnt <= (state == IDLE || stall || tick) ? '0 : qcnt + 1'b1;
      if (state_nx != state) begin
        q      <= '0;
        bitcnt <= 3'd7;
        have   <= 1'b0;
      end else begin
        if (tick)               q      <= q + 1'b1;
        if (bit_end)            bitcnt <= bitcnt - 1'b1;
        if (tx_pop || rx_push)  have   <= 1'b1;
      end
      if (state == START && tick)                             sh <= {saddr, rw};
      else if (tx_pop)                                        sh <= tx_dout;
      else if (bit_end && (state == ADDR || state == WDATA))  sh <= {sh[6:0], 1'b0};
      else if (sample && state == RDATA)                      sh <= {sh[6:0], sda_in};
      if (sample) ack_bit <= sda_in;
      if (go) cnt <= PWDATA[15:8];
      else if (bit_end && ((state == WACK && !ack_bit) || state == RACK)) cnt <= cnt - 1'b1;
      if (go)            nack <= 1'b0;
      else if (set_nack) nack <= 1'b1;
      if (go)                      ovf <= 1'b0;
      else if (data_wr && tx_full) ovf <= 1'b1;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSELx) begin
      case (PADDR[3:2])
        2'd0: PRDATA = {9'd0, saddr, cnt_reg, 5'd0, rw, 1'b0, en};
        2'd1: PRDATA = {16'd0, 4'(rx_lvl), 4'(tx_lvl), 3'd0, ovf, rx_empty, tx_full, nack,
                        state != IDLE};
        2'd2: PRDATA = {24'd0, rx_empty ? 8'd0 : rx_dout};
        default: PRDATA = 32'(div);
      endcase
    end
  end
endmodule

// File: doc/apb_i2c_master_fifo.md
Name: apb_i2c_master_fifo

Overview:
- Parametrised APB-slave I2C master; successor to the single-byte APB/I2C top, adding multi-byte bursts.
- Adds TX/RX FIFOs, a programmable SCL divider, read and write transfers, and NACK detection.
- Sits on the APB peripheral bus; drives an open-drain SDA line and a push-pull SCL line.

Parameters:
- FIFO_DEPTH, 4, entries in each of the TX and RX byte FIFOs (power of 2, 2..16).
- DIV_W, 16, width of the SCL quarter-period divider register.
- DIV_DEFAULT, 250, reset value of DIV (PCLK cycles per quarter SCL period, minus 1).

Ports:
- PCLK  in  1  APB clock; the only clock.
- PRESETn  in  1  asynchronous active-low reset.
- PADDR  in  32  APB address; only [3:2] is decoded.
- PSELx  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data.
- SDA  inout  1  I2C data; driven 0 or Z, never 1.
- SCL  out  1  I2C clock.

Behaviour:
- Interface: one clock, PCLK. Reset PRESETn is asynchronous and active-low.
- Reset values: PRDATA=0, SCL=1, SDA=Z, FSM=IDLE, FIFOs empty, all sticky bits 0, DIV=DIV_DEFAULT.
- APB: no wait states.
  - Write commits on PSELx&PENABLE&PWRITE.
  - Read data is combinational from PADDR while PSELx=1, and 0 otherwise.
- Register map, by PADDR[3:2]:
  - 0 CTRL (R/W):
    - [0] EN.
    - [1] GO: write-1 pulse, reads 0.
    - [2] RW: 0 = write, 1 = read.
    - [15:8] CNT: number of data bytes.
    - [22:16] SADDR: 7-bit slave address.
  - 1 STATUS (RO):
    - [0] BUSY, [1] NACK (sticky), [2] TX_FULL, [3] RX_EMPTY, [4] OVF (sticky).
    - [11:8] TX level, [15:12] RX level.
  - 2 DATA:
    - Write pushes PWDATA[7:0] to the TX FIFO.
    - A read access phase returns the RX head and pops it.
    - Popping an empty RX FIFO returns 0 and changes nothing.
    - A push to a full TX FIFO is dropped and sets OVF.
  - 3 DIV (R/W): [DIV_W-1:0].
- Divider and bit timing:
  - A quarter-tick fires every DIV+1 PCLK cycles; DIV=0 behaves as DIV=1.
  - Each bit takes 4 quarters:
    - Q0: SCL=0, SDA updated.
    - Q1: SCL=0.
    - Q2: SCL=1.
    - Q3: SCL=1; SDA is sampled on entry to Q3.
- FSM states: IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, STOP.
  - IDLE:
    - GO with EN=1 clears NACK and OVF, sets BUSY, loads the byte counter from CNT, and moves to START.
    - GO while BUSY is ignored.
  - START: with SCL=1, SDA falls to 0; one quarter later SCL falls.
  - ADDR: shifts out {SADDR,RW} MSB first.
  - ADDR_ACK: releases SDA and samples it.
    - SDA=1 → set NACK, go to STOP.
    - CNT=0 → STOP (address-only probe).
    - Otherwise → WDATA if RW=0, RDATA if RW=1.
  - WDATA:
    - Pops the TX FIFO at Q0 of bit 7, then shifts the byte out MSB first.
    - If the TX FIFO is empty, the FSM holds SCL=0 (master stall) until a byte arrives.
  - WACK:
    - SDA=1 → set NACK, flush TX FIFO, go to STOP.
    - Else decrement the counter; counter 0 → STOP, otherwise WDATA.
  - RDATA:
    - Samples 8 bits MSB first.
    - If the RX FIFO is full at the byte's end, the FSM holds SCL=0 until space frees.
    - Then pushes the byte and goes to RACK.
  - RACK:
    - Master drives ACK (SDA=0) if more bytes remain, or NACK (Z) on the last byte.
    - Then STOP or RDATA.
  - STOP: SDA=0 while SCL low, SCL rises, one quarter later SDA releases, then IDLE with BUSY=0.
- Counter: 8-bit. CNT greater than FIFO_DEPTH is legal for writes and reads; flow is handled by the stalls.
- EN=0 at any time:
  - Next cycle the FSM goes to IDLE, SCL=1, SDA=Z, BUSY=0.
  - Both FIFOs are flushed; no STOP is generated.
- A simultaneous APB push and FSM pop on the same cycle are both honoured; the level is unchanged.
- Asynchronous reset mid-transfer immediately forces all reset values.

Test Plan:
- Reset → PRDATA=0, SCL=1, SDA=Z, reading DIV returns 250, STATUS=0x0008.
- Write transfer:
  - Stimulus: DIV=1, push 0xA5 and 0x3C, CTRL={SADDR=0x50,CNT=2,RW=0,GO,EN}, bench slave ACKs.
  - Response: SDA carries start, 0xA0, ACK, 0xA5, ACK, 0x3C, ACK, stop; 4 PCLK per SCL half-period; BUSY ends at 0; NACK=0.
- Address NACK:
  - Stimulus: slave leaves SDA=Z during ADDR_ACK.
  - Response: NACK=1, stop generated, TX level=0, no data bits clocked.
- Read transfer:
  - Stimulus: CNT=3, RW=1, slave returns 0x11, 0x22, 0x33.
  - Response: master ACK, ACK, NACK; the RX reads return 0x11, 0x22, 0x33, then 0.
- TX starvation and overflow:
  - Stimulus: CNT=2 with one byte pushed.
  - Response: SCL held 0 after the first WACK until a second push, then resumes.
  - Stimulus: 5 pushes with depth 4.
  - Response: OVF=1, level=4.
- Abort:
  - Stimulus: clear EN mid-WDATA.
  - Response: within 1 cycle SCL=1, SDA=Z, BUSY=0, FIFOs empty.
  - Stimulus: assert PRESETn low mid-RDATA.
  - Response: reset values immediately.
